// File: rtl/lfsr_bist_pkg.sv
// lfsr_bist_pkg: shared FSM state type and mode encodings for the BIST LFSR engine
package lfsr_bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_PRPG = 1'b0;
    localparam logic MODE_MISR = 1'b1;

endpackage

// File: rtl/lfsr_step.sv
// lfsr_step: one combinational Galois LFSR/MISR step for an arbitrary width and tap mask
module lfsr_step #(
    parameter int                WIDTH = 16,
    parameter logic [WIDTH-1:0]  POLY  = 16'h0070
) (
    input  logic [WIDTH-1:0] state_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             misr_en_i,
    output logic [WIDTH-1:0] next_o
);

    logic fb;

    // Stage 0 always takes feedback, so the mask's bit 0 is ignored.
    assign fb     = state_i[WIDTH-1];
    assign next_o = {state_i[WIDTH-2:0], fb}
                  ^ ({WIDTH{fb}} & {POLY[WIDTH-1:1], 1'b0})
                  ^ ({WIDTH{misr_en_i}} & data_i);

endmodule

// File: rtl/lfsr_bist.sv
// lfsr_bist: BIST engine with a Galois LFSR (PRPG or MISR) and a start/busy/done pattern-count controller
module lfsr_bist
    import lfsr_bist_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = 16'h0070,
    parameter logic [WIDTH-1:0] SEED  = '1,
    parameter int               CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic             seed_load_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic [CNT_W-1:0] num_patterns_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] data_in_i,
    output logic [WIDTH-1:0] out_o,
    output logic             lfsr_out_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] count_o
);

    state_e             state_q, state_d;
    logic               mode_q, mode_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   lfsr_q, lfsr_d;
    logic [WIDTH-1:0]   step_nxt;
    logic [WIDTH-1:0]   seed_eff;
    logic               go, load, step, last;

    lfsr_step #(.WIDTH(WIDTH), .POLY(POLY)) u_step (
        .state_i   (lfsr_q),
        .data_i    (data_in_i),
        .misr_en_i (mode_q == MODE_MISR),
        .next_o    (step_nxt)
    );

    // Control decodes shared by the FSM and the datapath; start and seed_load only act outside RUN.
    assign go       = (state_q != RUN) && start_i;
    assign load     = (state_q != RUN) && seed_load_i;
    assign step     = (state_q == RUN) && enable_i;
    assign last     = (cnt_q + CNT_W'(1)) == num_q;
    assign seed_eff = (mode_i == MODE_PRPG && seed_i == '0) ? SEED : seed_i;

    // State, latched run parameters, counter and LFSR register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= MODE_PRPG;
            num_q   <= '0;
            cnt_q   <= '0;
            lfsr_q  <= SEED;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
        end
    end

    // Next state: a zero-length run goes straight to DONE; the final enabled step ends the run.
    always_comb begin
        state_d = go             ? (num_patterns_i == '0 ? DONE : RUN) :
                  (step && last) ? DONE : state_q;
        mode_d  = go ? mode_i : mode_q;
        num_d   = go ? num_patterns_i : num_q;
        cnt_d   = go ? '0 : step ? cnt_q + CNT_W'(1) : cnt_q;
        lfsr_d  = load ? seed_eff : step ? step_nxt : lfsr_q;
    end

    // Outputs come straight from registers.
    always_comb begin
        out_o      = lfsr_q;
        lfsr_out_o = lfsr_q[0];
        busy_o     = state_q == RUN;
        done_o     = state_q == DONE;
        count_o    = cnt_q;
    end

endmodule

// File: tb/tb_lfsr_bist.sv
// tb_lfsr_bist: directed vector table, randomized model comparison and async-reset check for lfsr_bist
module tb_lfsr_bist;

    localparam logic [15:0] POLY = 16'h0070;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, mode = 1'b0, seed_load = 1'b0, enable = 1'b0;
    logic [15:0] seed = '0, num = '0, din = '0;
    logic [15:0] out, count;
    logic        lfsr_out, busy, done;

    int checks = 0;
    int errors = 0;

    // Reference model: state as plain variables updated from the behavioural rules.
    logic [15:0] m_out = 16'hFFFF;
    logic [15:0] m_cnt = '0, m_num = '0;
    logic        m_busy = 1'b0, m_done = 1'b0, m_mode = 1'b0;

    typedef struct {
        logic        st, md, sl;
        logic [15:0] sd, np;
        logic        en;
        logic [15:0] dat;
        logic [15:0] e_out;
        logic        e_busy, e_done;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[19];

    lfsr_bist dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start),
        .mode_i         (mode),
        .seed_load_i    (seed_load),
        .seed_i         (seed),
        .num_patterns_i (num),
        .enable_i       (enable),
        .data_in_i      (din),
        .out_o          (out),
        .lfsr_out_o     (lfsr_out),
        .busy_o         (busy),
        .done_o         (done),
        .count_o        (count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Galois step as arithmetic: shift left, fold in tap mask (stage 0 always) when MSB was set.
    function automatic logic [15:0] ref_step(input logic [15:0] s, input logic [15:0] d, input logic misr);
        logic [15:0] n;
        n = s << 1;
        if (s[15]) n = n ^ (POLY | 16'h0001);
        if (misr) n = n ^ d;
        return n;
    endfunction

    task automatic model_reset();
        m_out = 16'hFFFF; m_cnt = '0; m_num = '0;
        m_busy = 1'b0; m_done = 1'b0; m_mode = 1'b0;
    endtask

    task automatic model_edge();
        if (m_busy) begin
            if (enable) begin
                m_out = ref_step(m_out, din, m_mode);
                m_cnt = m_cnt + 16'd1;
                if (m_cnt == m_num) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
        end else begin
            if (seed_load) m_out = (!mode && seed == 16'h0) ? 16'hFFFF : seed;
            if (start) begin
                m_mode = mode;
                m_num  = num;
                m_cnt  = '0;
                m_busy = (num != 16'h0);
                m_done = (num == 16'h0);
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_out"}, 32'(out), 32'(m_out));
        chk({tag, "_lfsr_out"}, 32'(lfsr_out), 32'(m_out[0]));
        chk({tag, "_busy"}, 32'(busy), 32'(m_busy));
        chk({tag, "_done"}, 32'(done), 32'(m_done));
        chk({tag, "_count"}, 32'(count), 32'(m_cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic st, input logic md, input logic sl, input logic [15:0] sd,
                         input logic [15:0] np, input logic en, input logic [15:0] dat);
        start = st; mode = md; seed_load = sl; seed = sd; num = np; enable = en; din = dat;
    endtask

    initial begin
        //            st md sl  seed     num     en  data     out      busy done count
        tbl[0]  = '{1'b1,1'b0,1'b0,16'h0000,16'd2,1'b1,16'h0000,16'hFFFF,1'b1,1'b0,16'd0};
        tbl[1]  = '{1'b0,1'b0,1'b0,16'h0000,16'd0,1'b1,16'h0000,16'hFF8F,1'b1,1'b0,16'd1};
        tbl[2]  = '{1'b0,1'b0,1'b0,16'h0000,16'd0,1'b1,16'h0000,16'hFF6F,1'b0,1'b1,16'd2};
        tbl[3]  = '{1'b0,1'b0,1'b0,16'h0000,16'd0,1'b0,16'h0000,16'hFF6F,1'b0,1'b1,16'd2};
        tbl[4]  = '{1'b0,1'b0,1'b1,16'h0000,16'd0,1'b0,16'h0000,16'hFFFF,1'b0,1'b1,16'd2};
        tbl[5]  = '{1'b0,1'b1,1'b1,16'h0000,16'd0,1'b0,16'h0000,16'h0000,1'b0,1'b1,16'd2};
        tbl[6]  = '{1'b1,1'b1,1'b0,16'h0000,16'd2,1'b1,16'h0000,16'h0000,1'b1,1'b0,16'd0};
        tbl[7]  = '{1'b0,1'b1,1'b0,16'h0000,16'd0,1'b1,16'h1234,16'h1234,1'b1,1'b0,16'd1};
        tbl[8]  = '{1'b0,1'b1,1'b0,16'h0000,16'd0,1'b1,16'h0001,16'h2469,1'b0,1'b1,16'd2};
        tbl[9]  = '{1'b1,1'b0,1'b0,16'h0000,16'd0,1'b1,16'h0000,16'h2469,1'b0,1'b1,16'd0};
        tbl[10] = '{1'b1,1'b0,1'b0,16'h0000,16'd1,1'b1,16'h0000,16'h2469,1'b1,1'b0,16'd0};
        tbl[11] = '{1'b0,1'b0,1'b0,16'h0000,16'd0,1'b1,16'h0000,16'h48D2,1'b0,1'b1,16'd1};
        tbl[12] = '{1'b0,1'b0,1'b1,16'h00AA,16'd0,1'b0,16'h0000,16'h00AA,1'b0,1'b1,16'd1};
        tbl[13] = '{1'b1,1'b0,1'b0,16'h0000,16'd3,1'b1,16'h0000,16'h00AA,1'b1,1'b0,16'd0};
        tbl[14] = '{1'b0,1'b0,1'b0,16'h0000,16'd0,1'b1,16'h0000,16'h0154,1'b1,1'b0,16'd1};
        tbl[15] = '{1'b1,1'b0,1'b1,16'h1111,16'd7,1'b0,16'h0000,16'h0154,1'b1,1'b0,16'd1};
        tbl[16] = '{1'b0,1'b0,1'b0,16'h0000,16'd0,1'b0,16'h0000,16'h0154,1'b1,1'b0,16'd1};
        tbl[17] = '{1'b0,1'b0,1'b0,16'h0000,16'd0,1'b1,16'h0000,16'h02A8,1'b1,1'b0,16'd2};
        tbl[18] = '{1'b0,1'b0,1'b0,16'h0000,16'd0,1'b1,16'h0000,16'h0550,1'b0,1'b1,16'd3};

        #12;
        chk("reset_out", 32'(out), 32'hFFFF);
        chk("reset_lfsr_out", 32'(lfsr_out), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_count", 32'(count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].st, tbl[i].md, tbl[i].sl, tbl[i].sd, tbl[i].np, tbl[i].en, tbl[i].dat);
            tick();
            chk($sformatf("vec%0d_out", i), 32'(out), 32'(tbl[i].e_out));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(tbl[i].e_done));
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
        end
        chk("model_sync_after_table", 32'(m_out), 32'h0550);

        for (int i = 0; i < 1500; i++) begin
            drive(($urandom % 8) == 0, 1'($urandom), ($urandom % 6) == 0,
                  (($urandom % 4) == 0) ? 16'h0 : 16'($urandom),
                  16'($urandom % 7), ($urandom % 4) != 0, 16'($urandom));
            tick();
            chk_model($sformatf("rnd%0d", i));
        end

        // Async reset mid-run: fresh run of 20, abort at count 5 between edges.
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
        drive(1'b1, 1'b0, 1'b1, 16'hBEEF, 16'd20, 1'b1, 16'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0);
        for (int i = 0; i < 5; i++) tick();
        chk_model("prerst");
        chk("prerst_count5", 32'(count), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out", 32'(out), 32'hFFFF);
        chk("arst_lfsr_out", 32'(lfsr_out), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        tick();
        chk_model("postrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
